// File: rtl/bcd_count_pkg.sv
// bcd_count_pkg: shared state encoding, BCD digit constants and digit validity helper.
package bcd_count_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_count_ctrl_if.sv
// bcd_count_ctrl_if: command/limit inputs and count/status outputs of the BCD counter.
// Lap capture signals exist only when BCD_COUNT_CTRL_LAP_EN is defined.
interface bcd_count_ctrl_if #(parameter int DIGITS = 4);
    logic                  tick;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  done;
    logic                  ovf;
`ifdef BCD_COUNT_CTRL_LAP_EN
    logic                  lap;
    logic [4*DIGITS-1:0]   lap_count;
    logic                  lap_valid;
    modport master (output tick, start, stop, clear, limit, lap, input count, running, done, ovf, lap_count, lap_valid);
    modport slave  (input tick, start, stop, clear, limit, lap, output count, running, done, ovf, lap_count, lap_valid);
`else
    modport master (output tick, start, stop, clear, limit, input count, running, done, ovf);
    modport slave  (input tick, start, stop, clear, limit, output count, running, done, ovf);
`endif
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one decade counter (0-9) with synchronous clear and ripple carry out.
module bcd_digit
    import bcd_count_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [BCD_W-1:0] o_q,
    output logic             o_carry
);
    logic [BCD_W-1:0] r_q;
    assign o_q     = r_q;
    assign o_carry = i_inc && r_q == BCD_MAX;
    // an out-of-range value can only arise from upset; it rolls to 0 rather than climbing
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_inc)
            r_q <= (o_carry || !bcd_valid(r_q)) ? '0 : r_q + 4'd1;
endmodule

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/pause/clear sequencer for a DIGITS-long BCD counter with terminal compare.
// Define BCD_COUNT_CTRL_LAP_EN to add the lap capture register.
module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bcd_count_ctrl_if.slave bus
);
    logic [DIGITS-1:0]   w_inc;
    logic [DIGITS-1:0]   w_carry;
    logic [4*DIGITS-1:0] w_count;
    logic [4*DIGITS-1:0] w_next;
    logic                w_cnt;
    logic                w_clr;
    logic                w_hit;
    logic                w_lim_ok;
    logic                w_go;
    state_t              r_state;
    state_t              w_state;
    logic                r_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        if (g == 0) begin : g_lsd
            assign w_inc[g] = w_cnt;
        end else begin : g_up
            assign w_inc[g] = w_carry[g-1];
        end
        assign w_next[4*g +: 4] = w_inc[g] ? (w_carry[g] ? 4'd0 : w_count[4*g +: 4] + 4'd1) : w_count[4*g +: 4];
        bcd_digit u_digit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (w_clr),
            .i_inc   (w_inc[g]),
            .o_q     (w_count[4*g +: 4]),
            .o_carry (w_carry[g])
        );
    end

    always_comb begin
        w_lim_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            w_lim_ok = w_lim_ok && bcd_valid(bus.limit[4*i +: 4]);
    end

    // STOP outranks START, so a coincident STOP blocks any start/resume
    assign w_go  = bus.start && !bus.stop && !bus.clear;
    assign w_cnt = r_state == RUN && bus.tick && !bus.stop && !bus.clear;
    assign w_clr = bus.clear || (r_state == DONE && w_go);
    assign w_hit = w_cnt && w_lim_ok && w_next == bus.limit;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ovf   <= w_cnt && w_carry[DIGITS-1];
        end

    always_comb begin
        w_state = r_state;
        case (r_state)
            IDLE:    w_state = w_go ? RUN : IDLE;
            RUN:     w_state = bus.stop ? PAUSE : (w_hit ? DONE : RUN);
            PAUSE:   w_state = w_go ? RUN : PAUSE;
            default: w_state = w_go ? RUN : DONE;
        endcase
        if (bus.clear)
            w_state = IDLE;
    end

    assign bus.count   = w_count;
    assign bus.running = r_state == RUN;
    assign bus.done    = r_state == DONE;
    assign bus.ovf     = r_ovf;

`ifdef BCD_COUNT_CTRL_LAP_EN
    logic [4*DIGITS-1:0] r_lap_count;
    logic                r_lap_valid;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_lap_count <= '0;
            r_lap_valid <= 1'b0;
        end else if (bus.clear) begin
            r_lap_count <= '0;
            r_lap_valid <= 1'b0;
        end else if (bus.lap && r_state != IDLE) begin
            r_lap_count <= w_count;
            r_lap_valid <= 1'b1;
        end
    assign bus.lap_count = r_lap_count;
    assign bus.lap_valid = r_lap_valid;
`endif
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_bcd_count_ctrl;
    typedef struct packed {
        logic [15:0] cnt;
        logic        run;
        logic        dn;
        logic        ovf;
        logic [15:0] lc;
        logic        lv;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    exp_t   q[$];
    string  nq[$];
    int     vecs = 0;
    int     errs = 0;

    bcd_count_ctrl_if #(.DIGITS(4)) bus ();
    bcd_count_ctrl #(.DIGITS(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc(input logic t, input logic s, input logic p, input logic c, input logic l = 1'b0);
        bus.tick = t; bus.start = s; bus.stop = p; bus.clear = c;
`ifdef BCD_COUNT_CTRL_LAP_EN
        bus.lap = l;
`endif
        @(posedge clk); #1;
        bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
`ifdef BCD_COUNT_CTRL_LAP_EN
        bus.lap = 0;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    task automatic expect_out(input string nm, input logic [15:0] c, input logic r, input logic d, input logic o,
                              input logic [15:0] lc = 16'h0, input logic lv = 1'b0);
        q.push_back('{cnt: c, run: r, dn: d, ovf: o, lc: lc, lv: lv});
        nq.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            logic  bad;
            e = q.pop_front();
            n = nq.pop_front();
            a = '{cnt: bus.count, run: bus.running, dn: bus.done, ovf: bus.ovf, lc: 16'h0, lv: 1'b0};
`ifdef BCD_COUNT_CTRL_LAP_EN
            a.lc = bus.lap_count;
            a.lv = bus.lap_valid;
`endif
            bad = a !== e;
            vecs++;
            if (bad) begin
                errs++;
                $display("FAIL %s: got count=%h run=%b done=%b ovf=%b lap=%h/%b, want count=%h run=%b done=%b ovf=%b lap=%h/%b",
                         n, a.cnt, a.run, a.dn, a.ovf, a.lc, a.lv, e.cnt, e.run, e.dn, e.ovf, e.lc, e.lv);
            end
        end
    end

    initial begin
        rst_n = 0;
        bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
        bus.limit = 16'h9999;
`ifdef BCD_COUNT_CTRL_LAP_EN
        bus.lap = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        expect_out("reset", 16'h0000, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_out("idle_tick", 16'h0000, 0, 0, 0);
        cyc(0, 1, 0, 0); expect_out("start", 16'h0000, 1, 0, 0);
        ticks(12); expect_out("count12", 16'h0012, 1, 0, 0);
        cyc(0, 0, 0, 1); expect_out("clear", 16'h0000, 0, 0, 0);

        bus.limit = 16'h0025;
        cyc(0, 1, 0, 0);
        ticks(24); expect_out("pre_limit", 16'h0024, 1, 0, 0);
        cyc(1, 0, 0, 0); expect_out("limit_done", 16'h0025, 0, 1, 0);
        ticks(5); expect_out("done_hold", 16'h0025, 0, 1, 0);
        cyc(0, 1, 0, 0); expect_out("done_restart", 16'h0000, 1, 0, 0);
        cyc(1, 0, 0, 0); expect_out("restart_tick", 16'h0001, 1, 0, 0);

        cyc(0, 0, 0, 1);
        bus.limit = 16'h9999;
        cyc(0, 1, 0, 0);
        ticks(9998); expect_out("at9998", 16'h9998, 1, 0, 0);
        cyc(1, 0, 0, 0); expect_out("done9999", 16'h9999, 0, 1, 0);

        cyc(0, 0, 0, 1);
        bus.limit = 16'hA000;
        cyc(0, 1, 0, 0);
        ticks(9998);
        cyc(1, 0, 0, 0); expect_out("free9999", 16'h9999, 1, 0, 0);
        cyc(1, 0, 0, 0); expect_out("wrap", 16'h0000, 1, 0, 1);
        cyc(0, 0, 0, 0); expect_out("ovf_once", 16'h0000, 1, 0, 0);

        ticks(7); expect_out("at7", 16'h0007, 1, 0, 0);
        cyc(1, 1, 1, 0); expect_out("stop_prio", 16'h0007, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_out("pause_tick", 16'h0007, 0, 0, 0);
        cyc(1, 1, 0, 0); expect_out("resume_tick", 16'h0007, 1, 0, 0);
        cyc(0, 1, 0, 1); expect_out("clear_prio", 16'h0000, 0, 0, 0);
        cyc(1, 1, 0, 0); expect_out("start_tick", 16'h0000, 1, 0, 0);

        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(431); expect_out("at0431", 16'h0431, 1, 0, 0);
        #6 rst_n = 0;
        bus.tick = 1;
        expect_out("async_rst", 16'h0000, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        bus.tick = 0;
        cyc(1, 0, 0, 0); expect_out("post_rst_tick", 16'h0000, 0, 0, 0);
        cyc(0, 1, 0, 0); expect_out("post_rst_start", 16'h0000, 1, 0, 0);

`ifdef BCD_COUNT_CTRL_LAP_EN
        ticks(99); expect_out("at0099", 16'h0099, 1, 0, 0);
        cyc(1, 0, 0, 0, 1); expect_out("lap", 16'h0100, 1, 0, 0, 16'h0099, 1);
        cyc(0, 0, 0, 1); expect_out("lap_clear", 16'h0000, 0, 0, 0, 16'h0000, 0);
        cyc(0, 0, 0, 0, 1); expect_out("lap_idle", 16'h0000, 0, 0, 0, 16'h0000, 0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errs++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
- Sequencer for a cascade of DIGITS decade (0-9) digit counters, forming a multi-digit BCD event/stopwatch counter.
- Runs, pauses, clears and stops the chain on a programmable BCD terminal value.
- Increments on a qualified TICK strobe from an upstream prescaler; feeds display/readout logic.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8); count width is 4*DIGITS.

Ports:
- CLK  in  1  system clock, rising-edge active.
- RST_N  in  1  asynchronous active-low reset.
- TICK  in  1  count strobe, one CLK cycle wide per event.
- START  in  1  command pulse: begin/resume counting.
- STOP  in  1  command pulse: pause counting.
- CLEAR  in  1  command pulse: zero count, return to IDLE.
- LIMIT  in  4*DIGITS  BCD terminal value; digit i at bits [4i+3:4i].
- COUNT  out  4*DIGITS  current BCD count, registered.
- RUNNING  out  1  high in RUN.
- DONE  out  1  high in DONE.
- OVF  out  1  one-cycle pulse on all-9s to all-0s wrap.

Behaviour:
- Reset (RST_N low, asynchronous): COUNT=0, state IDLE, RUNNING=0, DONE=0, OVF=0.
- All other updates occur on the rising edge of CLK.
- States:
  - IDLE: COUNT held at 0. START -> RUN.
  - RUN: each TICK increments COUNT by 1 in BCD.
    - STOP -> PAUSE.
    - Increment result == LIMIT -> DONE.
  - PAUSE: COUNT held; TICK ignored. START -> RUN.
  - DONE: COUNT held at LIMIT; TICK ignored. START -> clear COUNT to 0 and go to RUN in the same edge.
- Command priority when asserted in the same cycle: CLEAR > STOP > START.
  - CLEAR from any state: COUNT=0, state IDLE, next edge.
- BCD increment:
  - Digit 0 increments on TICK.
  - Digit i increments when all lower digits are 9 and TICK is high.
  - A digit at 9 that increments becomes 0 and carries.
  - Digit values never exceed 9.
- Wrap: all digits at 9 plus TICK in RUN gives COUNT=0 and OVF=1 for exactly one cycle; state remains RUN, unless LIMIT==0, in which case the state goes to DONE.
- Latency:
  - COUNT reflects a TICK on the edge where TICK is sampled.
  - DONE/RUNNING change on the same edge as the COUNT that caused them. No combinational paths from inputs to outputs.
- Simultaneous events:
  - TICK with START in IDLE/PAUSE: the tick is not counted; counting begins next cycle.
  - TICK with STOP in RUN: the tick is not counted.
  - TICK with CLEAR: COUNT=0.
- LIMIT:
  - Sampled continuously; changing it mid-run takes effect at the next compare.
  - A LIMIT containing any digit >9 never matches; the counter free-runs with OVF wraps.
  - LIMIT==0 is reached only via wrap.
- Reset mid-operation: immediate return to the reset values; no pending command survives.

Optional Feature:
- Macro: BCD_COUNT_CTRL_LAP_EN
- Defined:
  - Adds input LAP (pulse) and outputs LAP_COUNT (4*DIGITS) and LAP_VALID (1).
  - LAP in RUN/PAUSE/DONE captures COUNT (pre-increment value if TICK is coincident) into LAP_COUNT and sets LAP_VALID.
  - CLEAR or reset zeroes LAP_COUNT and clears LAP_VALID.
  - LAP in IDLE is ignored.
- Undefined: ports absent, no capture register; behaviour otherwise identical.

Decomposition:
- Package bcd_count_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}, 2-bit encoding.
  - BCD_W=4 and BCD_MAX=4'd9 constants.
  - Function bcd_valid(digit).
- Sub-module bcd_digit, instantiated DIGITS times:
  - Ports: CLK, RST_N, clr, inc, Q[3:0], carry.
  - carry = inc && Q==9; Q goes 9 -> 0 when inc.
- The controller holds the FSM, carry-chain enables, LIMIT compare and the OVF/lap logic.

Test Plan:
- Reset/basic count: RST_N low then high, START, 12 TICKs with LIMIT=16'h9999 -> COUNT=16'h0012, RUNNING=1, DONE=0, OVF=0.
- Terminal stop: LIMIT=16'h0025, START, 30 TICKs -> DONE=1 on the 25th tick's edge, COUNT holds 16'h0025; then START -> COUNT=0, RUN.
- Wrap: from 16'h9998 in RUN with LIMIT=16'h9999 first reach DONE; then repeat with LIMIT=16'hA000 (invalid) and 2 TICKs -> 16'h9999 then 16'h0000 with a one-cycle OVF, state RUN.
- Priority/coincidence:
  - STOP+START+TICK in RUN at 16'h0007 -> PAUSE, COUNT stays 16'h0007.
  - CLEAR+START -> IDLE, COUNT=0.
  - START+TICK in IDLE -> RUN, COUNT=0.
- Async reset mid-run: drop RST_N between edges at COUNT=16'h0431 -> outputs zero immediately, state IDLE, TICKs ignored until START.
- Lap (with BCD_COUNT_CTRL_LAP_EN): LAP with TICK at COUNT=16'h0099 -> LAP_COUNT=16'h0099, COUNT=16'h0100, LAP_VALID=1; CLEAR -> LAP_VALID=0.
